// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter that shares one uart transmitter between N_REQ sources,
// fetching each granted frame byte by byte and inserting an idle gap after every frame.
module uart_tx_arbiter #(
    parameter int N_REQ      = 2,
    parameter int MAX_LEN    = 16,
    parameter int LW         = 5,
    parameter int GAP_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*LW-1:0]   req_len,
    input  logic [N_REQ*8-1:0]    rd_data,
    output logic [N_REQ-1:0]      grant,
    output logic [LW-1:0]         rd_idx,
    output logic [N_REQ-1:0]      done,
    output logic                  busy,
    output logic [7:0]            tx_data,
    output logic                  tx_transmit,
    input  logic                  tx_ready
);

    localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_IDLE,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [SW-1:0]      sel_q, sel_d;
    logic [SW-1:0]      ptr_q, ptr_d;
    logic [LW-1:0]      len_q, len_d;
    logic [LW-1:0]      idx_q, idx_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_transmit_q, tx_transmit_d;
    logic [GW-1:0]      gap_q, gap_d;

    logic               pick_valid;
    logic [SW-1:0]      pick;
    logic [LW-1:0]      pick_len;
    logic               pick_len_ok;
    logic [N_REQ-1:0]   pick_onehot;
    logic [7:0]         sel_byte;
    logic [SW-1:0]      ptr_next;

    // Scan from the pointer downward so the requester closest after it wins last.
    always_comb begin
        int cand;
        pick_valid = 1'b0;
        pick       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = (int'(ptr_q) + k) % N_REQ;
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick       = SW'(cand);
            end
        end
    end

    assign pick_len    = req_len[int'(pick)*LW +: LW];
    assign pick_len_ok = (pick_len != '0) && (int'(pick_len) <= MAX_LEN);
    assign pick_onehot = N_REQ'(1) << pick;
    assign sel_byte    = rd_data[int'(sel_q)*8 +: 8];
    assign ptr_next    = (sel_q == SW'(N_REQ - 1)) ? '0 : sel_q + SW'(1);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        sel_d         = sel_q;
        ptr_d         = ptr_q;
        len_d         = len_q;
        idx_d         = idx_q;
        done_d        = '0;
        tx_data_d     = tx_data_q;
        tx_transmit_d = 1'b0;
        gap_d         = gap_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_onehot;
                    sel_d   = pick;
                    len_d   = pick_len;
                    idx_d   = '0;
                    if (pick_len_ok) begin
                        state_d = S_LOAD;
                    end else begin
                        done_d  = pick_onehot;
                        gap_d   = GW'(GAP_CYCLES);
                        state_d = S_GAP;
                    end
                end
            end
            S_LOAD: begin
                tx_data_d = sel_byte;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                if (tx_ready) begin
                    tx_transmit_d = 1'b1;
                    state_d       = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!tx_ready) state_d = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (tx_ready) begin
                    if (idx_q == len_q - LW'(1)) begin
                        done_d  = grant_q;
                        ptr_d   = ptr_next;
                        gap_d   = GW'(GAP_CYCLES);
                        state_d = S_GAP;
                    end else begin
                        idx_d   = idx_q + LW'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_GAP: begin
                // grant stays up through the done cycle and drops right after it
                grant_d = '0;
                if (gap_q == '0) state_d = S_IDLE;
                else             gap_d   = gap_q - GW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            sel_q         <= '0;
            ptr_q         <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            done_q        <= '0;
            tx_data_q     <= '0;
            tx_transmit_q <= 1'b0;
            gap_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            sel_q         <= sel_d;
            ptr_q         <= ptr_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            done_q        <= done_d;
            tx_data_q     <= tx_data_d;
            tx_transmit_q <= tx_transmit_d;
            gap_q         <= gap_d;
        end
    end

    assign grant       = grant_q;
    assign rd_idx      = idx_q;
    assign done        = done_q;
    assign busy        = (state_q != S_IDLE);
    assign tx_data     = tx_data_q;
    assign tx_transmit = tx_transmit_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: uart peer model plus a frame-level round-robin reference
// that predicts byte order, done order and the post-frame gap.
module tb_uart_tx_arbiter;

    localparam int N     = 2;
    localparam int ML    = 16;
    localparam int LW    = 5;
    localparam int GAP   = 100;
    localparam int UT    = 20;
    localparam int LIMIT = 60000;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*LW-1:0]  req_len;
    logic [N*8-1:0]   rd_data;
    logic [N-1:0]     grant;
    logic [LW-1:0]    rd_idx;
    logic [N-1:0]     done;
    logic             busy;
    logic [7:0]       tx_data;
    logic             tx_transmit;
    logic             tx_ready;

    logic [7:0] mem [N][ML];
    int         lens [N];
    int         cnt [N];
    int         ptr_m;
    int         exp_q[$], expd_q[$], obs_q[$], obsd_q[$];
    int         checks = 0;
    int         errors = 0;
    int         trunc_err = 0;
    int         bad_grant = 0;
    bit         uart_idle = 1'b1;
    bit         hold_low = 1'b0;
    int         ucnt = 0;

    uart_tx_arbiter #(.N_REQ(N), .MAX_LEN(ML), .LW(LW), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len), .rd_data(rd_data),
        .grant(grant), .rd_idx(rd_idx), .done(done), .busy(busy),
        .tx_data(tx_data), .tx_transmit(tx_transmit), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    assign tx_ready = uart_idle & ~hold_low;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N; i++)
            if (int'(rd_idx) < ML) rd_data[i*8 +: 8] = mem[i][int'(rd_idx)];
    end

    always_comb begin
        req_len = '0;
        for (int i = 0; i < N; i++) req_len[i*LW +: LW] = LW'(lens[i]);
    end

    // uart peer and observation monitor
    always @(negedge clk) begin
        if (tx_transmit) begin
            if (!tx_ready) trunc_err++;
            obs_q.push_back((int'(grant) << 8) | int'(tx_data));
            uart_idle = 1'b0;
            ucnt = UT;
        end else if (!uart_idle) begin
            ucnt--;
            if (ucnt == 0) uart_idle = 1'b1;
        end
        for (int i = 0; i < N; i++) if (done[i]) obsd_q.push_back(i);
        if (!$onehot0(grant)) bad_grant++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frames(input int c0, input int c1);
        int mc[N];
        int g;
        cnt[0] = c0;
        cnt[1] = c1;
        mc = cnt;
        while (mc[0] + mc[1] > 0) begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && mc[(ptr_m + k) % N] > 0) g = (ptr_m + k) % N;
            expd_q.push_back(g);
            if (lens[g] >= 1 && lens[g] <= ML) begin
                for (int b = 0; b < lens[g]; b++)
                    exp_q.push_back(((1 << g) << 8) | int'(mem[g][b]));
                ptr_m = (g + 1) % N;
            end
            mc[g]--;
        end
        for (int i = 0; i < N; i++) req[i] = (cnt[i] > 0);
    endtask

    task automatic finish_frames(input string tag);
        int cyc = 0;
        int t_done = -1;
        int t_idle = -1;
        while (((cnt[0] + cnt[1]) > 0 || busy) && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (done != '0) begin
                for (int i = 0; i < N; i++)
                    if (done[i] && cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) req[i] = 1'b0;
                    end
                t_done = cyc;
                t_idle = -1;
            end else if (!busy && t_idle < 0 && t_done >= 0) begin
                t_idle = cyc;
            end
        end
        chk({tag, " finished"}, int'(cyc < LIMIT), 1);
        chk({tag, " gap"}, t_idle - t_done, GAP + 1);
        chk({tag, " nbytes"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk({tag, " byte"}, obs_q[i], exp_q[i]);
        chk({tag, " ndone"}, obsd_q.size(), expd_q.size());
        for (int i = 0; i < obsd_q.size() && i < expd_q.size(); i++)
            chk({tag, " done_order"}, obsd_q[i], expd_q[i]);
        obs_q.delete();
        exp_q.delete();
        obsd_q.delete();
        expd_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ptr_m = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " grant"}, int'(grant), 0);
        chk({tag, " rd_idx"}, int'(rd_idx), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " tx_data"}, int'(tx_data), 0);
        chk({tag, " tx_transmit"}, int'(tx_transmit), 0);
    endtask

    initial begin
        logic [7:0] frame0 [9];
        int w;
        frame0 = '{8'hAA, 8'h80, 8'h80, 8'h00, 8'hC8, 8'h00, 8'h80, 8'h00, 8'h00};
        reset = 1'b1;
        req = '0;
        ptr_m = 0;
        for (int i = 0; i < N; i++) begin
            lens[i] = 0;
            cnt[i] = 0;
            for (int b = 0; b < ML; b++) mem[i][b] = 8'h00;
        end
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        // single frame with grant and first-strobe latency
        for (int b = 0; b < 9; b++) mem[0][b] = frame0[b];
        lens[0] = 9;
        @(negedge clk);
        start_frames(1, 0);
        @(negedge clk);
        chk("single grant", int'(grant), 1);
        chk("single busy", int'(busy), 1);
        @(negedge clk);
        chk("single early_strobe", int'(tx_transmit), 0);
        @(negedge clk);
        chk("single first_strobe", int'(tx_transmit), 1);
        chk("single first_data", int'(tx_data), 8'hAA);
        finish_frames("single");

        // contention from reset: 0,1,0,1
        do_reset();
        for (int i = 0; i < N; i++)
            for (int b = 0; b < ML; b++) mem[i][b] = 8'($urandom);
        lens[0] = 3;
        lens[1] = 2;
        start_frames(2, 2);
        finish_frames("contend");

        // zero and oversize lengths
        lens[0] = 0;
        lens[1] = 0;
        start_frames(1, 0);
        finish_frames("zero_len");
        lens[0] = ML + 1;
        start_frames(1, 0);
        finish_frames("oversize");

        // slow ready
        lens[0] = 1;
        hold_low = 1'b1;
        start_frames(1, 0);
        repeat (200) @(negedge clk);
        chk("slow no_strobe", obs_q.size(), 0);
        chk("slow busy", int'(busy), 1);
        hold_low = 1'b0;
        finish_frames("slow");

        // reset during byte 2 of a 5-byte frame
        lens[0] = 5;
        start_frames(1, 0);
        w = 0;
        while (obs_q.size() < 2 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("midreset reached_byte2", int'(obs_q.size() >= 2), 1);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_reset_outputs("midreset");
        chk("midreset no_done", obsd_q.size(), 0);
        obs_q.delete();
        exp_q.delete();
        obsd_q.delete();
        expd_q.delete();
        ptr_m = 0;
        @(negedge clk);
        reset = 1'b0;
        start_frames(1, 0);
        finish_frames("after_reset");

        // request dropped after first strobe
        lens[0] = 4;
        start_frames(1, 0);
        w = 0;
        while (obs_q.size() < 1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("drop reached_strobe", int'(obs_q.size() >= 1), 1);
        req[0] = 1'b0;
        finish_frames("dropped");

        // randomized frames against the reference
        for (int r = 0; r < 6; r++) begin
            int c0, c1;
            for (int i = 0; i < N; i++) begin
                for (int b = 0; b < ML; b++) mem[i][b] = 8'($urandom);
                if ($urandom_range(0, 5) == 0) lens[i] = ($urandom_range(0, 1) == 0) ? 0 : ML + 1;
                else lens[i] = $urandom_range(1, ML);
            end
            c0 = $urandom_range(0, 2);
            c1 = $urandom_range(0, 2);
            if (c0 + c1 == 0) c1 = 1;
            start_frames(c0, c1);
            finish_frames("random");
        end

        chk("no_truncated_byte", trunc_err, 0);
        chk("grant_onehot", bad_grant, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Frame-level round-robin arbiter and byte sequencer that shares the single `uart` transmitter between several frame sources, such as the Pong state-frame generator and a debug/event reporter. Each requester asks for the link with a frame length and serves bytes by index. The arbiter grants one requester per frame and drives the `uart` `tx_data`/`tx_transmit`/`tx_ready` handshake byte by byte. It inserts a programmable idle gap between frames so the host-side parser can resynchronise.

## Interface
- `N_REQ`, default 2: number of requesters (2..4).
- `MAX_LEN`, default 16: maximum frame length in bytes.
- `LW`, default 5: width of length/index fields; must satisfy 2^LW > MAX_LEN.
- `GAP_CYCLES`, default 50000: idle clocks inserted after each frame (0 = none).

Ports, clock and reset first:
- `clk`  in  1: system clock, 50 MHz.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  N_REQ: per-requester frame request (level).
- `req_len`  in  N_REQ*LW: per-requester frame length; slice i is `[i*LW +: LW]`. Latched at grant.
- `rd_data`  in  N_REQ*8: per-requester byte at index `rd_idx`; slice i is `[i*8 +: 8]`. Combinational from the requester.
- `grant`  out  N_REQ: one-hot; held for the whole frame.
- `rd_idx`  out  LW: index of the byte currently requested from the granted source.
- `done`  out  N_REQ: one-cycle pulse to the granted requester after its last byte completes.
- `busy`  out  1: high in every state except IDLE.
- `tx_data`  out  8: byte to `uart`.
- `tx_transmit`  out  1: one-cycle send strobe to `uart`.
- `tx_ready`  in  1: `uart` ready; goes low the cycle after an accepted strobe and returns high when the stop bit ends.

## Operation
- **Reset values** (asynchronous, apply immediately): `grant`=0, `rd_idx`=0, `done`=0, `busy`=0, `tx_data`=0, `tx_transmit`=0, state=IDLE, priority pointer=0, gap counter=0.
- **States:** IDLE, LOAD, ISSUE, WAIT_ACK, WAIT_IDLE, GAP.
- **IDLE:**
  - If any `req` bit is high, select the first requester at or after the pointer (mod N_REQ).
  - Set `grant` one-hot, latch `len`=`req_len` slice, set `rd_idx`=0.
  - If latched `len`=0 or `len`>MAX_LEN: pulse `done` and go to GAP. No bytes are sent.
  - Otherwise go to LOAD.
- **LOAD:** register `tx_data` from the granted `rd_data` slice, then go to ISSUE.
- **ISSUE:** when `tx_ready`=1, assert `tx_transmit` for exactly one cycle and go to WAIT_ACK. While `tx_ready`=0, hold in ISSUE with the strobe low.
- **WAIT_ACK:** wait for `tx_ready`=0, then go to WAIT_IDLE.
- **WAIT_IDLE:** wait for `tx_ready`=1. Then:
  - If `rd_idx`=`len`-1: pulse `done`, set pointer=granted+1 mod N_REQ, and go to GAP.
  - Otherwise: `rd_idx`+1 and go to LOAD.
- **GAP:**
  - On entry, `grant` clears and the counter loads GAP_CYCLES.
  - Counts down to 0, then goes to IDLE.
  - With GAP_CYCLES=0, go straight to IDLE.
- **Requester rules:**
  - `req` is sampled only in IDLE. Dropping `req` mid-frame is ignored; the frame completes.
  - A requester holding `req` high after `done` is re-arbitrated normally. Round-robin guarantees another pending requester is served first.
- **Simultaneous requests:** the pointer decides. After reset the pointer is 0, so requester 0 wins.
- **Reset mid-frame:** the frame is abandoned with no `done`. A byte already accepted by `uart` finishes on the line. Because ISSUE waits for `tx_ready`=1, the next frame never truncates it.
- **Widths:** `rd_idx` compares against `len`-1 in LW bits. `len`≥1 is guaranteed on that path, so there is no wrap.

## Timing
- **Grant:** `req` high in IDLE gives `grant` and `busy` high on the next clock edge.
- **First strobe:** `tx_transmit` rises 2 cycles after grant (LOAD, then ISSUE), provided `tx_ready`=1.
- **Data stability:** `tx_data` is stable from LOAD until the next LOAD, and is valid in the strobe cycle.
- **Requester data:** `rd_data` must be valid combinationally in the LOAD cycle for the current `rd_idx`.
- **Byte spacing:** one strobe per `uart` byte. Spacing is the `uart` frame time plus 3 clocks (WAIT_IDLE exit, LOAD, ISSUE).
- **Done:** the `done` pulse coincides with the cycle `tx_ready` returns high after the last byte. `grant` drops the following cycle.
- **Rearbitration:** the next grant comes no earlier than GAP_CYCLES+1 cycles after `done`.

## Test plan
- **Single frame:** reset; req0, `req_len`0=9, bytes AA,80,80,00,C8,00,80,00,00, with a `uart` model.
  - Expect 9 strobes in order, `done`[0] once after the 9th, `grant`=01 throughout, and `busy` low after GAP_CYCLES=100.
- **Contention:** req0 and req1 both high, len 3 and 2.
  - Expect order frame0, frame1, frame0, frame1.
  - Neither requester is granted twice in a row while the other is pending.
- **Zero and oversize length:** `req_len`=0, then `req_len`=MAX_LEN+1.
  - Expect `done` pulses, zero `tx_transmit`, and a GAP after each.
- **Slow ready:** hold `tx_ready` low for 200 cycles in ISSUE.
  - Expect no strobe until it rises, then exactly one strobe.
- **Reset mid-frame:** pulse `reset` during byte 2 of a 5-byte frame.
  - Expect all outputs at reset values in the same cycle and no `done`.
  - The next frame's first strobe waits until `tx_ready`=1.
- **Request dropped mid-frame:** deassert `req0` after the first strobe of a 4-byte frame.
  - Expect all 4 bytes sent and `done`[0] asserted.
